// File: rtl/pulse_spacer.sv
// Purpose : paces bursty single-cycle event requests into sig_a pulses spaced GAP_CYCLES+1 apart.
// Latency : req in an idle cycle with nothing queued -> sig_a one cycle later; queued events follow.
// Backpressure: none upstream; excess events wait in a saturating counter, overflow drops and sets ovf.
//
// Ports:
//   clka    - fast-domain clock
//   rst     - synchronous reset, active-high
//   req     - event request, one event per high cycle
//   clr_ovf - clears the sticky drop flag
//   sig_a   - registered single-cycle paced pulse toward the slow-domain synchronizer
//   pend    - registered count of queued, not yet launched events
//   busy    - pulse/gap in progress or events queued (registers only)
//   ovf     - sticky: at least one event was dropped
module pulse_spacer #(
  parameter  int GAP_CYCLES = 9,
  parameter  int PEND_MAX   = 15,
  localparam int PEND_W     = $clog2(PEND_MAX + 1),
  localparam int CNT_W      = $clog2(GAP_CYCLES + 1)
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              req,
  input  logic              clr_ovf,
  output logic              sig_a,
  output logic [PEND_W-1:0] pend,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               sig_a_q, sig_a_d;
  logic               ovf_q, ovf_d;

  logic decide;   // a launch may be decided this cycle
  logic launch;   // an event is consumed this cycle
  logic deq;      // the consumed event comes from the queue
  logic enq;      // req wants a queue slot (not consumed directly)
  logic drop;     // queue full and no slot freed this cycle

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;

    decide = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == CNT_W'(1)));
    launch = decide && (req || (pend_q != '0));
    // Queued events take priority over a fresh req so ordering is preserved.
    deq    = launch && (pend_q != '0);
    enq    = req && !(launch && (pend_q == '0));
    drop   = enq && (pend_q == PEND_W'(PEND_MAX)) && !deq;

    case (state_q)
      IDLE: begin
        if (launch) state_d = PULSE;
      end
      PULSE: begin
        state_d = GAP;
        cnt_d   = CNT_W'(GAP_CYCLES);
      end
      GAP: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Going straight back to PULSE keeps back-to-back spacing at GAP_CYCLES+1.
          state_d = launch ? PULSE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({enq && !drop, deq})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase

    // A drop in the same cycle as a clear wins so no drop is ever lost.
    ovf_d   = drop || (ovf_q && !clr_ovf);
    sig_a_d = (state_d == PULSE);
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      sig_a_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sig_a_q <= sig_a_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sig_a = sig_a_q;
  assign pend  = pend_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_spacer.sv
// Purpose : scoreboard bench for pulse_spacer against a time-based pacing model.
// Latency : expected values for cycle t+1 are queued while cycle t inputs are applied.
// Backpressure: n/a; the DUT output is observed every cycle and on every sig_a pulse.
module tb_pulse_spacer;

  localparam int GAP      = 9;
  localparam int PEND_MAX = 15;
  localparam int PEND_W   = $clog2(PEND_MAX + 1);

  logic              clka = 1'b0;
  logic              rst, req, clr_ovf;
  logic              sig_a, busy, ovf;
  logic [PEND_W-1:0] pend;

  pulse_spacer #(.GAP_CYCLES(GAP), .PEND_MAX(PEND_MAX)) dut (
    .clka    (clka),
    .rst     (rst),
    .req     (req),
    .clr_ovf (clr_ovf),
    .sig_a   (sig_a),
    .pend    (pend),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit sig;
    int pend;
    bit ovf;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the registers should show in the current cycle.
  int m_pend    = 0;
  bit m_ovf     = 0;
  int m_last    = -1000;   // cycle of the most recent pulse
  int n_req     = 0;
  int n_drop    = 0;
  int n_discard = 0;
  int n_pulses  = 0;

  // Pacing rule: after a pulse at p, the next launch may be decided at p+GAP
  // (pulse at p+GAP+1); whenever eligible, one event (queued first) goes out.
  task automatic model_cycle(input int t, input bit r, input bit c, input bit rs);
    exp_t e;
    bit   eligible, launch, from_q;
    int   p;
    if (rs) begin
      n_discard += m_pend;
      m_pend = 0;
      m_ovf  = 0;
      m_last = -1000;
    end else begin
      if (r) n_req++;
      eligible = (t >= m_last + GAP);
      launch   = eligible && (r || m_pend > 0);
      from_q   = launch && (m_pend > 0);
      p = m_pend - (from_q ? 1 : 0);
      if (r && !(launch && !from_q)) begin
        if (p < PEND_MAX) p++;
        else begin
          n_drop++;
          m_ovf = 1;
        end
      end else if (c) m_ovf = 0;
      if (r && p == PEND_MAX && !(launch && !from_q) && m_ovf && c) m_ovf = 1;
      if (c && !(r && !(launch && !from_q) && m_pend - (from_q ? 1 : 0) >= PEND_MAX)) m_ovf = 0;
      m_pend = p;
      if (launch) begin
        m_last = t + 1;
        pulse_q.push_back(t + 1);
      end
    end
    e.cyc  = t + 1;
    e.sig  = (m_last == t + 1);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    e.busy = (m_pend > 0) || ((t + 1) - m_last <= GAP);
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit c, input bit rs);
    @(posedge clka);
    #1;
    req     = r;
    clr_ovf = c;
    rst     = rs;
    model_cycle(cyc, r, c, rs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: per-cycle register image plus pulse-timing scoreboard.
  bit prev_sig = 0;
  int seen_pulses = 0;
  always @(negedge clka) begin
    exp_t e;
    int   tp;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_cmp += 4;
      if (sig_a !== e.sig) begin
        n_bad++;
        $display("FAIL sig_a cyc=%0d got=%0b exp=%0b", cyc, sig_a, e.sig);
      end
      if (int'(pend) != e.pend || $isunknown(pend)) begin
        n_bad++;
        $display("FAIL pend cyc=%0d got=%0d exp=%0d", cyc, pend, e.pend);
      end
      if (ovf !== e.ovf) begin
        n_bad++;
        $display("FAIL ovf cyc=%0d got=%0b exp=%0b", cyc, ovf, e.ovf);
      end
      if (busy !== e.busy) begin
        n_bad++;
        $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, e.busy);
      end
    end
    if (sig_a === 1'b1) begin
      seen_pulses++;
      n_cmp += 2;
      if (pulse_q.size() == 0) begin
        n_bad++;
        $display("FAIL pulse_time cyc=%0d got=unexpected pulse exp=none", cyc);
      end else begin
        tp = pulse_q.pop_front();
        if (tp != cyc) begin
          n_bad++;
          $display("FAIL pulse_time got=%0d exp=%0d", cyc, tp);
        end
      end
      if (prev_sig) begin
        n_bad++;
        $display("FAIL pulse_adjacent cyc=%0d got=high twice exp=isolated", cyc);
      end
    end
    n_cmp++;
    if (int'(pend) > PEND_MAX) begin
      n_bad++;
      $display("FAIL pend_bound cyc=%0d got=%0d exp<=%0d", cyc, pend, PEND_MAX);
    end
    prev_sig = (sig_a === 1'b1);
  end

  initial begin
    int density;
    bit r, c, rs;
    req = 0; clr_ovf = 0; rst = 1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    idle(6);

    // Single event from idle, then a short burst that queues two events.
    step(1'b1, 1'b0, 1'b0);
    idle(15);
    burst(3);
    idle(30);

    // req landing exactly in the last gap cycle with nothing queued.
    step(1'b1, 1'b0, 1'b0);
    idle(GAP);
    step(1'b1, 1'b0, 1'b0);
    idle(25);

    // Long burst from idle: the queue fills and exactly one event is dropped.
    burst(18);
    idle(200);

    // Reset mid-gap with events queued.
    burst(7);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    idle(30);

    // Dropping req and clr_ovf together, then clr_ovf alone.
    burst(17);
    step(1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    idle(200);

    // Randomized traffic with occasional clears and resets.
    density = 50;
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) density = $urandom_range(5, 95);
      r  = ($urandom_range(0, 99) < density);
      c  = ($urandom_range(0, 99) < 4);
      rs = ($urandom_range(0, 299) == 0);
      step(r, c, rs);
    end
    idle(PEND_MAX * (GAP + 1) + 20);
    @(negedge clka);
    @(negedge clka);

    n_cmp += 2;
    if (pulse_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_pulses got=%0d outstanding exp=0", pulse_q.size());
    end
    if (seen_pulses != n_req - n_drop - n_discard - m_pend) begin
      n_bad++;
      $display("FAIL conservation got=%0d pulses exp=%0d", seen_pulses,
               n_req - n_drop - n_discard - m_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
